wb_regfile_stage: RTL and testbench

Writeback and register-file stage directly downstream of the execute stage.
- Consumes the execute stage's wb_en / rd_addr / result / branch_en outputs.
- Commits results into a 16-entry register file and provides two bypassed read ports to the decode/issue stage.
- Tracks in-flight destination registers in a scoreboard to raise a hazard stall.
- Turns a taken branch into a registered PC redirect.

---
 rtl/wb_regfile_stage.sv | 112 +++++++++++
 tb/tb_wb_regfile_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage
//   Writeback / register-file stage that sits directly after execute.
//   - Commits execute results into a 2**AW entry register file.
//   - Two combinational read ports with zero-latency write-to-read bypass.
//   - One busy bit per register tracks in-flight writers; hazard_o asks
//     decode to hold while an operand or the destination is still pending.
//   - A taken branch becomes a one-cycle registered PC redirect.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   wb_en_i         : execute result valid for register write
//   wb_addr_i       : destination register of the execute result
//   wb_data_i       : execute result (branch target when branch_en_i=1)
//   branch_en_i     : taken branch reported by execute
//   ra_addr_i/ra_data_o, rb_addr_i/rb_data_o : bypassed read ports
//   issue_i, issue_wb_i, issue_addr_i, kill_i : decode issue request
//   hazard_o        : decode must hold this cycle
//   pc_load_o       : PC redirect strobe (one cycle)
//   pc_target_o     : redirect target, holds its last value
//   retire_cnt_o    : count of committed register writes (wraps)
//
// Handshake: decode presents issue_i with its operands; the issue is taken
// in a cycle where hazard_o=0 and kill_i=0. While hazard_o=1 decode keeps
// the same request asserted and nothing in this stage changes for it.

module wb_regfile_stage #(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int PCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wb_en_i,
  input  logic [AW-1:0]  wb_addr_i,
  input  logic [DW-1:0]  wb_data_i,
  input  logic           branch_en_i,
  input  logic [AW-1:0]  ra_addr_i,
  input  logic [AW-1:0]  rb_addr_i,
  output logic [DW-1:0]  ra_data_o,
  output logic [DW-1:0]  rb_data_o,
  input  logic           issue_i,
  input  logic           issue_wb_i,
  input  logic [AW-1:0]  issue_addr_i,
  input  logic           kill_i,
  output logic           hazard_o,
  output logic           pc_load_o,
  output logic [PCW-1:0] pc_target_o,
  output logic [31:0]    retire_cnt_o
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] busy_next;
  logic            sb_set;
  logic            pc_load;
  logic [PCW-1:0]  pc_target;
  logic [31:0]     retire_cnt;

  // Read ports: a same-cycle write to the addressed register is forwarded.
  always_comb begin
    ra_data_o = regs[ra_addr_i];
    rb_data_o = regs[rb_addr_i];
    if (wb_en_i && (wb_addr_i == ra_addr_i)) ra_data_o = wb_data_i;
    if (wb_en_i && (wb_addr_i == rb_addr_i)) rb_data_o = wb_data_i;
  end

  // A register being written back this cycle is already resolved, so it
  // does not count as busy for the hazard check.
  always_comb begin
    busy_eff = busy;
    if (wb_en_i) busy_eff[wb_addr_i] = 1'b0;
  end

  assign hazard_o = issue_i & (busy_eff[ra_addr_i] | busy_eff[rb_addr_i] |
                               (issue_wb_i & busy_eff[issue_addr_i]));

  assign sb_set = issue_i & issue_wb_i & ~kill_i & ~hazard_o;

  // Clear first, then set, so a new writer to the register retiring this
  // cycle keeps its busy bit.
  always_comb begin
    busy_next = busy;
    if (wb_en_i) busy_next[wb_addr_i] = 1'b0;
    if (sb_set)  busy_next[issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy       <= '0;
      pc_load    <= 1'b0;
      pc_target  <= '0;
      retire_cnt <= '0;
    end else begin
      if (wb_en_i) begin
        regs[wb_addr_i] <= wb_data_i;
        retire_cnt      <= retire_cnt + 32'd1;
      end
      busy    <= busy_next;
      pc_load <= branch_en_i;
      if (branch_en_i) pc_target <= wb_data_i[PCW-1:0];
    end
  end

  assign pc_load_o    = pc_load;
  assign pc_target_o  = pc_target;
  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: directed scenarios followed by random traffic,
// all compared against a reference model holding the register contents, the
// list of in-flight destination registers, the redirect state and the
// retire count.

module tb_wb_regfile_stage;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_i;
  logic [3:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        branch_en_i;
  logic [3:0]  ra_addr_i;
  logic [3:0]  rb_addr_i;
  logic [31:0] ra_data_o;
  logic [31:0] rb_data_o;
  logic        issue_i;
  logic        issue_wb_i;
  logic [3:0]  issue_addr_i;
  logic        kill_i;
  logic        hazard_o;
  logic        pc_load_o;
  logic [15:0] pc_target_o;
  logic [31:0] retire_cnt_o;

  always #5 clk = ~clk;

  wb_regfile_stage #(.DW(32), .AW(4), .PCW(16)) dut (
    .clk(clk), .rst(rst),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .branch_en_i(branch_en_i),
    .ra_addr_i(ra_addr_i), .rb_addr_i(rb_addr_i),
    .ra_data_o(ra_data_o), .rb_data_o(rb_data_o),
    .issue_i(issue_i), .issue_wb_i(issue_wb_i), .issue_addr_i(issue_addr_i),
    .kill_i(kill_i), .hazard_o(hazard_o),
    .pc_load_o(pc_load_o), .pc_target_o(pc_target_o),
    .retire_cnt_o(retire_cnt_o)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [16];
  int          m_inflight[$];   // destination registers with a pending writer
  logic        m_pc_load;
  logic [15:0] m_pc_target;
  logic [31:0] m_retire;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pending(input logic [3:0] r);
    foreach (m_inflight[i]) if (m_inflight[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  // A register still awaits its writer unless that writer retires right now.
  function automatic bit still_busy(input logic [3:0] r);
    return pending(r) && !(wb_en_i && wb_addr_i == r);
  endfunction

  function automatic bit exp_hazard();
    if (!issue_i) return 1'b0;
    return still_busy(ra_addr_i) || still_busy(rb_addr_i) ||
           (issue_wb_i && still_busy(issue_addr_i));
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] r);
    if (wb_en_i && wb_addr_i == r) return wb_data_i;
    return m_regs[r];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic br,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic iss, input logic iwb, input logic [3:0] ia,
                       input logic kl);
    rst = r; wb_en_i = we; wb_addr_i = wa; wb_data_i = wd; branch_en_i = br;
    ra_addr_i = ra; rb_addr_i = rb;
    issue_i = iss; issue_wb_i = iwb; issue_addr_i = ia; kill_i = kl;
    #1;
  endtask

  task automatic check_all();
    check("ra_data", ra_data_o, exp_read(ra_addr_i));
    check("rb_data", rb_data_o, exp_read(rb_addr_i));
    check("hazard", {31'd0, hazard_o}, {31'd0, exp_hazard()});
    check("pc_load", {31'd0, pc_load_o}, {31'd0, m_pc_load});
    check("pc_target", {16'd0, pc_target_o}, {16'd0, m_pc_target});
    check("retire_cnt", retire_cnt_o, m_retire);
  endtask

  // Advance one clock and update the model with what the edge commits.
  task automatic tick();
    bit haz;
    haz = exp_hazard();
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_inflight.delete();
      m_pc_load = 1'b0;
      m_pc_target = '0;
      m_retire = '0;
    end else begin
      if (wb_en_i) begin
        m_regs[wb_addr_i] = wb_data_i;
        m_retire = m_retire + 1;
        for (int i = m_inflight.size() - 1; i >= 0; i--)
          if (m_inflight[i] == int'(wb_addr_i)) m_inflight.delete(i);
      end
      if (issue_i && issue_wb_i && !kill_i && !haz)
        m_inflight.push_back(int'(issue_addr_i));
      m_pc_load = branch_en_i;
      if (branch_en_i) m_pc_target = wb_data_i[15:0];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_pc_load = 0; m_pc_target = 0; m_retire = 0;

    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // 1. reset state, all addresses read zero
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 4'(i), 4'(15 - i), 0, 0, 0, 0);
      check_all();
      check("rst_ra_zero", ra_data_o, 32'd0);
    end
    check("rst_retire", retire_cnt_o, 32'd0);
    check("rst_pc_load", {31'd0, pc_load_o}, 32'd0);
    // writes, an issue and a branch during reset are all discarded
    drive(1, 1, 4, 32'hCAFE_0004, 1, 4, 4, 1, 1, 4, 0);
    tick();
    idle();
    ra_addr_i = 4; #1;
    check_all();
    check("rst_write_dropped", ra_data_o, 32'd0);
    check("rst_retire_hold", retire_cnt_o, 32'd0);

    // 2. write r5 with same-cycle bypass
    drive(0, 1, 5, 32'hDEAD_BEEF, 0, 5, 0, 0, 0, 0, 0);
    check_all();
    check("bypass_r5", ra_data_o, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0);
    check_all();
    check("stored_r5", ra_data_o, 32'hDEAD_BEEF);
    check("retire_one", retire_cnt_o, 32'd1);
    tick();

    // 3. RAW hazard on r3 and its release
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0);
    check_all();
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
      check_all();
      check("raw_hazard", {31'd0, hazard_o}, 32'd1);
      tick();
    end
    drive(0, 1, 3, 32'h12, 0, 1, 3, 1, 0, 0, 0);
    check_all();
    check("raw_release", {31'd0, hazard_o}, 32'd0);
    check("raw_bypass", rb_data_o, 32'h12);
    tick();

    // 4. set wins over clear on r7; killed issue leaves r8 free
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0);
    tick();
    drive(0, 1, 7, 32'h77, 0, 0, 0, 1, 1, 7, 0);
    check_all();
    check("waw_retire_issue", {31'd0, hazard_o}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0);
    check_all();
    check("set_wins", {31'd0, hazard_o}, 32'd1);
    tick();
    drive(0, 1, 7, 32'h78, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 8, 1);
    tick();
    drive(0, 0, 0, 0, 0, 8, 8, 1, 0, 0, 0);
    check_all();
    check("kill_no_busy", {31'd0, hazard_o}, 32'd0);
    tick();

    // 5. branch redirect, single and back-to-back
    drive(0, 0, 0, 32'h0001_00A4, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    check_all();
    check("br_pulse", {31'd0, pc_load_o}, 32'd1);
    check("br_target", {16'd0, pc_target_o}, 32'h00A4);
    tick();
    check_all();
    check("br_pulse_end", {31'd0, pc_load_o}, 32'd0);
    check("br_target_hold", {16'd0, pc_target_o}, 32'h00A4);
    drive(0, 1, 2, 32'h0000_1111, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 32'h0000_2222, 1, 2, 0, 0, 0, 0, 0);
    check_all();
    check("br2_first", {16'd0, pc_target_o}, 32'h1111);
    check("br_with_write", ra_data_o, 32'h1111);
    tick();
    idle();
    check_all();
    check("br2_second", {16'd0, pc_target_o}, 32'h2222);
    check("br2_pulse", {31'd0, pc_load_o}, 32'd1);
    tick();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), $urandom(),
            ($urandom_range(0, 4) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      check_all();
      tick();
    end

    // 6. retire counter wrap
    idle();
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    m_retire = 32'hFFFF_FFFF;
    drive(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    check("cnt_preload", retire_cnt_o, 32'hFFFF_FFFF);
    tick();
    idle();
    check_all();
    check("cnt_wrap", retire_cnt_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
